// File: rtl/react_pkg.sv
// Shared types and constants for the reaction-timer result statistics.
package react_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LATCH = 2'd1, S_UPDATE = 2'd2} state_t;

  localparam logic [1:0]  SEL_LAST  = 2'd0;
  localparam logic [1:0]  SEL_BEST  = 2'd1;
  localparam logic [1:0]  SEL_AVG   = 2'd2;
  localparam logic [1:0]  SEL_FAULT = 2'd3;

  localparam logic [15:0] BEST_NONE = 16'hFFFF;
  localparam logic [15:0] MAX_MS    = 16'd9999;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction
endpackage

// File: rtl/hist4_avg.sv
// Shift history of the last DEPTH valid samples with a running sum for the mean.
module hist4_avg #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] sample,
  output logic [15:0] avg,
  output logic        full
);
  localparam int         SH       = $clog2(DEPTH);
  localparam logic [2:0] FULL_CNT = 3'(DEPTH);

  logic [DEPTH-1:0][15:0] h;
  logic [17:0]            sum;
  logic [2:0]             cnt;

  // Entries start at zero, so subtracting the oldest is correct before the history fills.
  always_ff @(posedge clk) begin
    if (clear) begin
      h   <= '0;
      sum <= '0;
      cnt <= '0;
    end else if (load) begin
      h   <= {h[DEPTH-2:0], sample};
      sum <= sum + 18'(sample) - 18'(h[DEPTH-1]);
      if (cnt != FULL_CNT) cnt <= cnt + 3'd1;
    end
  end

  assign full = (cnt == FULL_CNT);
  assign avg  = full ? sum[SH+15:SH] : 16'd0;
endmodule

// File: rtl/react_stats.sv
// Captures finished reaction times and keeps last/best/average/false-start statistics
// with a registered display select.
module react_stats #(
  parameter logic [15:0] MAX_MS = react_pkg::MAX_MS,
  parameter int          HIST   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        result_valid,
  input  logic [15:0] result,
  input  logic [1:0]  sel,
  output logic [15:0] disp,
  output logic [15:0] best,
  output logic [15:0] avg,
  output logic        avg_valid,
  output logic [3:0]  trials,
  output logic [3:0]  faults,
  output logic        new_best,
  output logic        busy
);
  import react_pkg::*;

  state_t      state, state_nxt;
  logic        wipe, take, upd, fault;
  logic [15:0] sample_q, last_q, disp_nxt;

  assign wipe  = rst | clear;
  assign fault = (sample_q == 16'd0);

  always_ff @(posedge clk) begin
    if (wipe) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (result_valid) state_nxt = S_LATCH;
      S_LATCH:  state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    take = (state == S_IDLE) && result_valid;
    upd  = (state == S_UPDATE);
  end

  hist4_avg #(.DEPTH(HIST)) u_hist (
    .clk    (clk),
    .clear  (wipe),
    .load   (upd && !fault),
    .sample (sample_q),
    .avg    (avg),
    .full   (avg_valid)
  );

  always_comb begin
    disp_nxt = last_q;
    case (sel)
      SEL_LAST:  disp_nxt = last_q;
      SEL_BEST:  disp_nxt = (best == BEST_NONE) ? 16'd0 : best;
      SEL_AVG:   disp_nxt = avg;
      SEL_FAULT: disp_nxt = {12'd0, faults};
      default:   disp_nxt = last_q;
    endcase
  end

  // A wipe during S_LATCH/S_UPDATE discards the held sample before it touches any statistic.
  always_ff @(posedge clk) begin
    if (wipe) begin
      sample_q <= '0;
      last_q   <= '0;
      best     <= BEST_NONE;
      trials   <= '0;
      faults   <= '0;
      new_best <= 1'b0;
      disp     <= '0;
    end else begin
      new_best <= 1'b0;
      disp     <= disp_nxt;
      if (take) sample_q <= (result > MAX_MS) ? MAX_MS : result;
      if (upd) begin
        if (fault) begin
          faults <= sat_inc4(faults);
        end else begin
          last_q <= sample_q;
          trials <= sat_inc4(trials);
          if (sample_q < best) begin
            best     <= sample_q;
            new_best <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_react_stats.sv
// Randomized and directed checks of react_stats against a list-based statistics model.
module tb_react_stats;
  logic        clk = 0, rst = 1, clear = 0, result_valid = 0;
  logic [15:0] result = 0;
  logic [1:0]  sel = 0;
  logic [15:0] disp, best, avg;
  logic        avg_valid, new_best, busy;
  logic [3:0]  trials, faults;

  int total = 0, bad = 0;

  // model: plain list of accepted samples plus scalar counters
  int m_hist[$];
  int m_last, m_best, m_trials, m_faults;

  react_stats dut (
    .clk(clk), .rst(rst), .clear(clear), .result_valid(result_valid), .result(result),
    .sel(sel), .disp(disp), .best(best), .avg(avg), .avg_valid(avg_valid),
    .trials(trials), .faults(faults), .new_best(new_best), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void m_reset();
    m_hist.delete();
    m_last = 0; m_best = 65535; m_trials = 0; m_faults = 0;
  endfunction

  // returns 1 when the sample lowers the best
  function automatic bit m_apply(input int r);
    int s = (r > 9999) ? 9999 : r;
    bit nb = 0;
    if (s == 0) begin
      if (m_faults < 15) m_faults++;
    end else begin
      m_last = s;
      if (m_trials < 15) m_trials++;
      m_hist.push_back(s);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      if (s < m_best) begin m_best = s; nb = 1; end
    end
    return nb;
  endfunction

  function automatic int m_avg();
    int sum = 0;
    if (m_hist.size() < 4) return 0;
    foreach (m_hist[i]) sum += m_hist[i];
    return sum / 4;
  endfunction

  function automatic int m_disp(input int s);
    case (s)
      0: return m_last;
      1: return (m_best == 65535) ? 0 : m_best;
      2: return m_avg();
      default: return m_faults;
    endcase
  endfunction

  // One result pulse; records new_best and busy on the 4 cycles that follow the pulse.
  task automatic send(input logic [15:0] r, output logic [3:0] nb, output logic [1:0] bz);
    @(negedge clk); result = r; result_valid = 1;
    nb = '0; bz = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      result_valid = 0;
      nb[k-1] = new_best;
      if (k <= 2) bz[k-1] = busy;
    end
  endtask

  task automatic test_reset();
    rst = 1; repeat (3) @(negedge clk); rst = 0;
    m_reset();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); @(negedge clk); @(negedge clk);
      total++; if (disp !== 16'd0) begin bad++; $display("FAIL reset_disp sel=%0d got=%0d want=0", s, disp); end
    end
    total++;
    if (best !== 16'hFFFF || trials !== 4'd0 || faults !== 4'd0 || avg_valid !== 1'b0 ||
        avg !== 16'd0 || busy !== 1'b0 || new_best !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got best=%h trials=%0d faults=%0d avg_valid=%b avg=%0d busy=%b nb=%b want FFFF/0/0/0/0/0/0",
               best, trials, faults, avg_valid, avg, busy, new_best);
    end
  endtask

  task automatic test_sequence();
    int vals[5]       = '{300, 250, 400, 200, 500};
    int want_best[5]  = '{300, 250, 250, 200, 200};
    int npulse = 0;
    logic [3:0] nb; logic [1:0] bz; bit enb;
    sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      enb = m_apply(vals[i]);
      send(16'(vals[i]), nb, bz);
      if (nb != 0) npulse++;
      total++; if (nb !== (enb ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL seq_new_best i=%0d got=%b want=%b", i, nb, enb ? 4'b0100 : 4'b0000); end
      total++; if (bz !== 2'b11) begin bad++; $display("FAIL seq_busy i=%0d got=%b want=11", i, bz); end
      total++; if (best !== 16'(want_best[i])) begin bad++; $display("FAIL seq_best i=%0d got=%0d want=%0d", i, best, want_best[i]); end
      total++; if (disp !== 16'(want_best[i])) begin bad++; $display("FAIL seq_disp i=%0d got=%0d want=%0d", i, disp, want_best[i]); end
      total++; if (avg !== 16'(m_avg()) || avg_valid !== (i >= 3)) begin bad++; $display("FAIL seq_avg i=%0d got=%0d/%b want=%0d/%b", i, avg, avg_valid, m_avg(), i >= 3); end
      if (i == 3) begin
        total++; if (avg !== 16'd287) begin bad++; $display("FAIL seq_avg4 got=%0d want=287", avg); end
        total++; if (npulse != 3) begin bad++; $display("FAIL seq_pulses got=%0d want=3", npulse); end
      end
    end
    total++; if (avg !== 16'd337 || trials !== 4'd5) begin bad++; $display("FAIL seq_fifth got avg=%0d trials=%0d want 337/5", avg, trials); end
    sel = 2'd2; @(negedge clk);
    total++; if (disp !== 16'd337) begin bad++; $display("FAIL seq_disp_avg got=%0d want=337", disp); end
  endtask

  task automatic test_fault_clamp();
    logic [3:0] nb; logic [1:0] bz;
    for (int i = 0; i < 3; i++) begin
      void'(m_apply(0)); send(16'd0, nb, bz);
      total++; if (nb !== 4'b0000) begin bad++; $display("FAIL fault_nb i=%0d got=%b want=0000", i, nb); end
    end
    void'(m_apply(12000)); send(16'd12000, nb, bz);
    sel = 2'd3; @(negedge clk);
    total++; if (disp !== 16'd3 || faults !== 4'd3) begin bad++; $display("FAIL fault_count got disp=%0d faults=%0d want 3/3", disp, faults); end
    sel = 2'd0; @(negedge clk);
    total++; if (disp !== 16'd9999) begin bad++; $display("FAIL clamp_last got=%0d want=9999", disp); end
    total++; if (best !== 16'(m_best) || trials !== 4'(m_trials)) begin bad++; $display("FAIL fault_keep got best=%0d trials=%0d want %0d/%0d", best, trials, m_best, m_trials); end
  endtask

  task automatic test_back_to_back();
    int t0 = m_trials;
    @(negedge clk); result = 16'd7000; result_valid = 1;
    @(negedge clk); result = 16'd1;
    @(negedge clk); result_valid = 0;
    void'(m_apply(7000));
    repeat (5) @(negedge clk);
    total++; if (trials !== 4'(t0 + 1)) begin bad++; $display("FAIL b2b_trials got=%0d want=%0d", trials, t0 + 1); end
    total++; if (best !== 16'(m_best)) begin bad++; $display("FAIL b2b_best got=%0d want=%0d", best, m_best); end
  endtask

  task automatic test_clear_abort();
    int seen = 0;
    @(negedge clk); result = 16'd777; result_valid = 1;
    @(negedge clk); result_valid = 0; clear = 1;
    @(negedge clk); clear = 0;
    m_reset();
    total++;
    if (best !== 16'hFFFF || trials !== 0 || faults !== 0 || avg !== 0 || avg_valid !== 0 ||
        busy !== 0 || disp !== 0) begin
      bad++;
      $display("FAIL clear_abort got best=%h trials=%0d faults=%0d avg=%0d av=%b busy=%b disp=%0d want reset values",
               best, trials, faults, avg, avg_valid, busy, disp);
    end
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (new_best) seen++; end
    total++; if (seen != 0 || trials !== 0) begin bad++; $display("FAIL clear_no_update got pulses=%0d trials=%0d want 0/0", seen, trials); end
    @(negedge clk); result = 16'd5; result_valid = 1; clear = 1;
    @(negedge clk); result_valid = 0; clear = 0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_wins_busy got=%b want=0", busy); end
    repeat (4) @(negedge clk);
    total++; if (best !== 16'hFFFF || trials !== 0) begin bad++; $display("FAIL clear_wins_stats got best=%h trials=%0d want FFFF/0", best, trials); end
  endtask

  task automatic test_random();
    logic [3:0] nb; logic [1:0] bz; bit enb; int r;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 6))
        0, 1: r = 0;
        2:    r = $urandom_range(10000, 65535);
        3:    r = (m_best == 65535) ? 600 : m_best;
        default: r = $urandom_range(1, 9999);
      endcase
      sel = 2'($urandom_range(0, 3));
      enb = m_apply(r);
      send(16'(r), nb, bz);
      total++;
      if (nb !== (enb ? 4'b0100 : 4'b0000) || best !== 16'(m_best) || avg !== 16'(m_avg()) ||
          avg_valid !== (m_hist.size() == 4) || trials !== 4'(m_trials) || faults !== 4'(m_faults) ||
          disp !== 16'(m_disp(sel))) begin
        bad++;
        $display("FAIL rand i=%0d r=%0d got nb=%b best=%0d avg=%0d av=%b tr=%0d fa=%0d disp=%0d want nb=%b best=%0d avg=%0d tr=%0d fa=%0d disp=%0d",
                 i, r, nb, best, avg, avg_valid, trials, faults, disp,
                 enb ? 4'b0100 : 4'b0000, m_best, m_avg(), m_trials, m_faults, m_disp(sel));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_fault_clamp();
    test_back_to_back();
    test_clear_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
